muldiv_seq: RTL

- Iterative multiply/divide sequencer that owns the HI/LO register pair for the core.
- Accepts multiply/divide commands from the decode stage (MULTIPLY path), runs a radix-2 shift-add / restoring-divide loop, and writes HI/LO.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Asserts STALL to the pipeline whenever an access would collide with an operation still in flight.

---
 rtl/muldiv_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Iterative multiply/divide sequencer that owns the HI/LO pair.
//             It runs a radix-2 shift-add multiply or a restoring divide,
//             serves MTHI/MTLO writes, and stalls the pipeline while busy.
//  Option   : MULDIV_FAST_MUL_EN - single-cycle multiplier for MULT/MULTU
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic             MT_HI,
  input  logic             MT_LO,
  input  logic [WIDTH-1:0] MT_DATA,
  input  logic             RD_REQ,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             STALL
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [2*WIDTH-1:0]     r_acc;      // {HI-half, LO-half}: {prod} or {rem, quo}
  logic [WIDTH-1:0]       r_opnd;     // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]       r_a_raw;    // original dividend, returned on divide-by-zero
  logic                   r_is_div;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_b_zero;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  // Operand magnitudes; OP[0] marks signed ops, OP[1] marks divides
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  assign w_mag_a = (OP[0] && SRC_A[WIDTH-1]) ? (-SRC_A) : SRC_A;
  assign w_mag_b = (OP[0] && SRC_B[WIDTH-1]) ? (-SRC_B) : SRC_B;

  // Multiply step: conditional add into upper half, keep the carry, shift right
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_mul_nxt;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: the shifted remainder needs one extra bit before the trial subtract
  logic [WIDTH:0]         w_rem_sh;
  logic                   w_no_borrow;
  logic [WIDTH-1:0]       w_diff;
  logic [2*WIDTH-1:0]     w_div_nxt;
  assign w_rem_sh    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_no_borrow = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff      = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_nxt   = w_no_borrow ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                                   : {r_acc[2*WIDTH-2:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]     w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

  // Sign correction and result selection used at the FIX writeback
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_fix_hi;
  logic [WIDTH-1:0]       w_fix_lo;
  assign w_prod = r_neg_q ? (-r_acc) : r_acc;

  // Pick the value written to HI/LO when the operation completes
  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_neg_q ? (-r_acc[WIDTH-1:0])       : r_acc[WIDTH-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
`ifdef MULDIV_FAST_MUL_EN
          w_state_nxt = OP[1] ? S_CALC : S_FIX;
`else
          w_state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command latch, loop iteration, writeback and MT writes
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_is_div <= OP[1];
            r_neg_q  <= OP[0] & (SRC_A[WIDTH-1] ^ SRC_B[WIDTH-1]);
            r_neg_r  <= OP[0] & SRC_A[WIDTH-1];
            r_a_raw  <= SRC_A;
            r_b_zero <= (SRC_B == '0);
            r_cnt    <= '0;
            // The multiplier rides in the cleared lower half and shifts out as
            // product bits shift in; the dividend does the same for the quotient.
            r_acc    <= OP[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_opnd   <= OP[1] ? w_mag_b : w_mag_a;
`ifdef MULDIV_FAST_MUL_EN
            if (!OP[1]) r_acc <= w_fast_prod;
`endif
          end else begin
            if (MT_HI) r_hi <= MT_DATA;
            if (MT_LO) r_lo <= MT_DATA;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign HI    = r_hi;
  assign LO    = r_lo;
  assign BUSY  = (r_state != S_IDLE);
  assign STALL = BUSY & (START | MT_HI | MT_LO | RD_REQ);

endmodule
`default_nettype wire
